// File: rtl/cbus_arbiter_pkg.sv
// Cache-bus payload types shared by the cbus arbiter, its interface and its users.
package cbus_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ORDER_W = 2;

    // Burst length is 2**order beats.
    typedef struct packed {
        logic               valid;
        logic               is_write;
        logic [ADDR_W-1:0]  addr;
        logic [ORDER_W-1:0] order;
        logic [DATA_W-1:0]  wdata;
    } cbus_req_t;

    typedef struct packed {
        logic              okay;
        logic              last;
        logic [DATA_W-1:0] rdata;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the arbiter's upstream request/response arrays and its single downstream port.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2
);

    cbus_req_t  cbus_reqs  [NUM_INPUTS];
    cbus_resp_t cbus_resps [NUM_INPUTS];
    cbus_req_t  mux_req;
    cbus_resp_t mux_resp;

    // slave: the arbiter's view; master: the requesters plus the downstream bridge.
    modport slave (
        input  cbus_reqs,
        input  mux_resp,
        output cbus_resps,
        output mux_req
    );

    modport master (
        output cbus_reqs,
        output mux_resp,
        input  cbus_resps,
        input  mux_req
    );

endinterface

// File: rtl/cbus_arbiter.sv
// N-to-1 cache-bus arbiter: grants one requester per transaction and holds it until the last beat.
// Define CBUS_ARBITER_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2
) (
    input  logic          clk,
    input  logic          resetn,
    cbus_arbiter_if.slave bus
);

    localparam int unsigned      IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_grant_nxt;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic [NUM_INPUTS-1:0] valids;

    // Gather request valids into a vector for the winner search.
    always_comb begin
        valids = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            valids[i] = bus.cbus_reqs[i].valid;
        end
    end

`ifdef CBUS_ARBITER_RR_EN
    logic [IDX_W-1:0] cand;

    // Search starts just after the previous grant, wrapping modulo NUM_INPUTS.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_INPUTS);
            if (!found && valids[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (!found && valids[i]) begin
                winner = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= LAST_IDX;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state and the owner-only request/response routing.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        bus.mux_req    = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            bus.cbus_resps[i] = '0;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = BUSY;
                    owner_nxt      = winner;
                    last_grant_nxt = winner;
                end
            end
            BUSY: begin
                bus.mux_req           = bus.cbus_reqs[owner];
                bus.cbus_resps[owner] = bus.mux_resp;
                if (bus.mux_resp.last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: random requesters, a downstream responder and a grant-order model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned N       = 2;
    localparam int unsigned TIMEOUT = 200;

    typedef struct {
        int unsigned idx;
        cbus_req_t   req;
        int unsigned start;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_INPUTS(N)) ifc ();

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    exp_t        exp_q[$];
    int unsigned cyc      = 0;
    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_done = 0;
    int unsigned lg       = N - 1;
    int unsigned last_w   = 0;
    bit          abort_run = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Reference grant rule, computed from the set of pending requesters.
    function automatic int unsigned pick(input logic [N-1:0] mask, input int unsigned prev);
`ifdef CBUS_ARBITER_RR_EN
        for (int unsigned k = 1; k <= N; k++) begin
            if (mask[(prev + k) % N]) return (prev + k) % N;
        end
`else
        for (int unsigned k = 0; k < N; k++) begin
            if (mask[k]) return k;
        end
`endif
        return 0;
    endfunction

    function automatic logic [N-1:0] pending();
        logic [N-1:0] m;
        for (int unsigned i = 0; i < N; i++) m[i] = ifc.cbus_reqs[i].valid;
        return m;
    endfunction

    task automatic set_req(input int unsigned i, input logic wr, input logic [31:0] addr,
                           input logic [1:0] ord, input logic [31:0] wd);
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.order    = ord;
        r.wdata    = wd;
        ifc.cbus_reqs[i] = r;
    endtask

    task automatic rand_req(input int unsigned i);
        set_req(i, 1'($urandom_range(1)), {4'(i), 28'($urandom)}, 2'($urandom_range(3)), $urandom);
    endtask

    // Predict the next grant, then wait for the responder to finish it.
    task automatic run_round(input bit arrivals);
        exp_t        e;
        int unsigned w;
        int unsigned n;
        if (abort_run) return;
        w       = pick(pending(), lg);
        lg      = w;
        e.idx   = w;
        e.req   = ifc.cbus_reqs[w];
        e.start = cyc + 1;
        e.abort = 1'b0;
        exp_q.push_back(e);
        exp_done++;
        n = 0;
        while (done_cnt < exp_done && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
            if (arrivals) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (i != w && !ifc.cbus_reqs[i].valid && $urandom_range(7) == 0) rand_req(i);
                end
            end
        end
        if (done_cnt < exp_done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout cyc=%0d got done=%0d want done=%0d", cyc, done_cnt, exp_done);
            abort_run = 1'b1;
        end
        ifc.cbus_reqs[w] = '0;
        last_w = w;
    endtask

    task automatic check_beat(input exp_t e, input cbus_resp_t drv);
        check("hold_mux_req", 128'(ifc.mux_req), 128'(e.req));
        for (int unsigned i = 0; i < N; i++) begin
            check($sformatf("route_resp%0d", i), 128'(ifc.cbus_resps[i]),
                  (i == e.idx) ? 128'(drv) : 128'(0));
        end
    endtask

    // Downstream responder and output monitor.
    initial begin : monitor
        exp_t        e;
        cbus_resp_t  drv;
        int unsigned nbeats;
        ifc.mux_resp = '0;
        forever begin
            @(posedge clk);
            #1;
            ifc.mux_resp = '0;
            @(negedge clk);
            if (ifc.mux_req.valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant cyc=%0d got addr=%h want no grant", cyc, ifc.mux_req.addr);
                    abort_run = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    check("grant_latency", 128'(cyc), 128'(e.start));
                    check_beat(e, '0);
                    nbeats = e.abort ? 2 : (1 << e.req.order);
                    for (int unsigned b = 0; b < nbeats; b++) begin
                        if (!e.abort && $urandom_range(3) == 0) begin
                            @(posedge clk);
                            #1;
                            drv.okay  = 1'b0;
                            drv.last  = 1'b0;
                            drv.rdata = $urandom;
                            ifc.mux_resp = drv;
                            @(negedge clk);
                            check_beat(e, drv);
                        end
                        @(posedge clk);
                        #1;
                        drv.okay  = 1'b1;
                        drv.last  = 1'(!e.abort && b == nbeats - 1);
                        drv.rdata = $urandom;
                        ifc.mux_resp = drv;
                        @(negedge clk);
                        check_beat(e, drv);
                    end
                    if (e.abort) begin
                        @(posedge clk);
                        #1;
                        drv.okay  = 1'b1;
                        drv.last  = 1'b0;
                        drv.rdata = $urandom;
                        ifc.mux_resp = drv;
                        @(negedge clk);
                        check("reset_mux_req", 128'(ifc.mux_req), 128'(0));
                        for (int unsigned i = 0; i < N; i++) begin
                            check($sformatf("reset_resp%0d", i), 128'(ifc.cbus_resps[i]), 128'(0));
                        end
                    end
                    done_cnt++;
                end
            end else begin
                check("idle_mux_req", 128'(ifc.mux_req), 128'(0));
                for (int unsigned i = 0; i < N; i++) begin
                    check($sformatf("idle_resp%0d", i), 128'(ifc.cbus_resps[i]), 128'(0));
                end
                if (exp_q.size() > 0 && cyc > exp_q[0].start && !abort_run) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_missing cyc=%0d got no valid want grant at cyc %0d", cyc, exp_q[0].start);
                    abort_run = 1'b1;
                end
            end
        end
    end

    task automatic reset_test();
        exp_t e;
        for (int unsigned i = 0; i < N; i++) ifc.cbus_reqs[i] = '0;
        set_req(0, 1'b0, 32'h1fc0_0040, 2'd2, 32'h0);
        e.idx   = 0;
        e.req   = ifc.cbus_reqs[0];
        e.start = cyc + 1;
        e.abort = 1'b1;
        exp_q.push_back(e);
        exp_done++;
        lg = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        lg     = N - 1;
        for (int unsigned i = 0; i < N; i++) ifc.cbus_reqs[i] = '0;
        rand_req(0);
        rand_req(1);
        run_round(1'b0);
        rand_req(0);
        run_round(1'b0);
        run_round(1'b0);
    endtask

    initial begin : stim
        resetn = 1'b0;
        for (int unsigned i = 0; i < N; i++) ifc.cbus_reqs[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        set_req(0, 1'b0, 32'h1fc0_0000, 2'd2, 32'h0);
        run_round(1'b0);
        set_req(1, 1'b1, 32'h0000_2000, 2'd1, 32'hdead_beef);
        run_round(1'b0);

        for (int r = 0; r < 40 && !abort_run; r++) begin
            if ($urandom_range(1) == 1) rand_req(last_w);
            for (int unsigned i = 0; i < N; i++) begin
                if (!ifc.cbus_reqs[i].valid && $urandom_range(2) == 0) rand_req(i);
            end
            if (pending() == '0) rand_req($urandom_range(N - 1));
            run_round(1'b1);
        end

        for (int r = 0; r < 6 && !abort_run; r++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!ifc.cbus_reqs[i].valid) rand_req(i);
            end
            run_round(1'b0);
        end

        if (!abort_run) reset_test();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
